// File: rtl/alu_mc_exec.sv
// ---------------------------------------------------------------------------
// alu_mc_exec
//   Multi-cycle ALU execution unit. It takes the 4-bit code from the ALU
//   control decoder and the A/B operands from the register file or immediate
//   mux. Shifts are done iteratively, SHIFT_STEP bits per cycle. Every other
//   operation, and any shift by zero, finishes in a single cycle. Both sides
//   use valid/ready handshakes, so the upstream datapath stalls on shifts and
//   the downstream consumer can apply backpressure.
//
// Parameters
//   WIDTH       operand/result width (power of two, >= 8)
//   SHIFT_STEP  bits shifted per SHIFT cycle (1, 2, 4 or 8)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  unit can accept a request (IDLE only)
//   alu_ctrl   in   operation code
//   op_a       in   operand A
//   op_b       in   operand B / shift amount source (low log2(WIDTH) bits)
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   result     out  operation result
//   zero       out  result == 0
//   illegal    out  alu_ctrl was 1011..1111
//   busy       out  unit is not IDLE
// ---------------------------------------------------------------------------
module alu_mc_exec #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    // The remaining-shift counter is one bit wider than a shift amount. That
    // lets SHIFT_STEP (up to 8) sit in the same width even when WIDTH is 8.
    localparam logic [SHW:0] C_STEP = (SHW+1)'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Single-cycle result. A shift only takes this path when its amount is
    // zero, so the result is simply A. Illegal codes produce 0.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       c,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (c)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SLL,
            OP_SRL,
            OP_SRA:   r = a;
            OP_SLT:   r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_PASSB: r = b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_shift_done;

    logic [3:0]       r_ctrl;
    logic [WIDTH-1:0] r_val;
    logic [SHW:0]     r_rem;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic             w_is_shift_in;
    logic             w_start_shift;
    logic             w_illegal_in;
    logic [WIDTH-1:0] w_single;
    logic [SHW:0]     w_step;
    logic [SHW:0]     w_rem_next;
    logic [WIDTH-1:0] w_shifted;

    // Request decode
    assign w_is_shift_in = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) ||
                           (alu_ctrl == OP_SRA);
    assign w_start_shift = w_is_shift_in && (op_b[SHW-1:0] != '0);
    assign w_illegal_in  = (alu_ctrl > OP_PASSB);
    assign w_single      = alu_single(alu_ctrl, op_a, op_b);

    // Shift step: move by min(SHIFT_STEP, remaining) this cycle
    assign w_step     = (r_rem < C_STEP) ? r_rem : C_STEP;
    assign w_rem_next = r_rem - w_step;

    // SRA keeps the sign bit in place on every step, so the fill is always the
    // original A[WIDTH-1].
    always_comb begin
        w_shifted = r_val;
        case (r_ctrl)
            OP_SLL:  w_shifted = r_val << w_step;
            OP_SRL:  w_shifted = r_val >> w_step;
            OP_SRA:  w_shifted = WIDTH'($signed(r_val) >>> w_step);
            default: w_shifted = r_val;
        endcase
    end

    // Control FSM: next state
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_shift_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_rem_next == '0) begin
                    w_shift_done = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Working registers: hold the latched request and the partial shift.
    // They need no reset because they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ctrl <= alu_ctrl;
            r_val  <= op_a;
            r_rem  <= {1'b0, op_b[SHW-1:0]};
        end else if (r_state == S_SHIFT) begin
            r_val  <= w_shifted;
            r_rem  <= w_rem_next;
        end
    end

    // Result registers: loaded only when the operation completes. They then
    // hold through DONE and afterwards until the next completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_start_shift) begin
            r_result  <= w_single;
            r_zero    <= (w_single == '0);
            r_illegal <= w_illegal_in;
        end else if (w_shift_done) begin
            r_result  <= w_shifted;
            r_zero    <= (w_shifted == '0);
            r_illegal <= 1'b0;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_mc_exec.sv
module tb_alu_mc_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic        iv[2];
    logic        ordy[2];
    logic        ir[2];
    logic        ov[2];
    logic        zo[2];
    logic        il[2];
    logic        bz[2];
    logic [31:0] rs[2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0: one bit per shift cycle; instance 1: four bits per cycle
    alu_mc_exec #(.WIDTH(32), .SHIFT_STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .alu_ctrl(ctrl), .op_a(a), .op_b(b), .out_valid(ov[0]),
        .out_ready(ordy[0]), .result(rs[0]), .zero(zo[0]),
        .illegal(il[0]), .busy(bz[0])
    );

    alu_mc_exec #(.WIDTH(32), .SHIFT_STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .alu_ctrl(ctrl), .op_a(a), .op_b(b), .out_valid(ov[1]),
        .out_ready(ordy[1]), .result(rs[1]), .zero(zo[1]),
        .illegal(il[1]), .busy(bz[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result straight from the operation definitions; latency is
    // one cycle plus ceil(shamt/step) shift cycles for nonzero shifts.
    task automatic model(input logic [3:0] c, input logic [31:0] ma, input logic [31:0] mb,
                         input int step, output logic [31:0] r, output logic ill,
                         output int lat);
        int sh;
        sh  = int'(mb[4:0]);
        ill = 1'b0;
        lat = 1;
        case (c)
            4'd0:  r = ma + mb;
            4'd1:  r = ma - mb;
            4'd2:  r = ma & mb;
            4'd3:  r = ma | mb;
            4'd4:  r = ma ^ mb;
            4'd5:  begin r = ma << sh; lat = 1 + (sh + step - 1) / step; end
            4'd6:  begin r = ma >> sh; lat = 1 + (sh + step - 1) / step; end
            4'd7:  begin r = 32'($signed(ma) >>> sh); lat = 1 + (sh + step - 1) / step; end
            4'd8:  r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
            4'd9:  r = (ma < mb) ? 32'd1 : 32'd0;
            4'd10: r = mb;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endtask

    // One full transaction on instance s with out_ready held high
    task automatic run_op(input int s, input logic [3:0] c, input logic [31:0] ai,
                          input logic [31:0] bi, input string tag, input logic [31:0] er,
                          input logic ez, input logic ei, input int el);
        int lat;
        logic stall_bad;
        chk1({tag, "_in_ready_idle"}, ir[s], 1'b1);
        ctrl = c; a = ai; b = bi;
        ordy[s] = 1'b1;
        iv[s] = 1'b1;
        tick();
        iv[s] = 1'b0;
        ctrl = ~c; a = ~ai; b = ~bi;  // changes after accept must be ignored
        lat = 1;
        stall_bad = 1'b0;
        while (!ov[s] && lat < 100) begin
            if (ir[s] || !bz[s]) stall_bad = 1'b1;
            tick();
            lat++;
        end
        chk1({tag, "_out_valid"}, ov[s], 1'b1);
        chk({tag, "_latency"}, 32'(lat), 32'(el));
        chk({tag, "_result"}, rs[s], er);
        chk1({tag, "_zero"}, zo[s], ez);
        chk1({tag, "_illegal"}, il[s], ei);
        chk1({tag, "_stall_ready"}, stall_bad, 1'b0);
        chk1({tag, "_in_ready_done"}, ir[s], 1'b0);
        tick();
        chk1({tag, "_out_valid_drop"}, ov[s], 1'b0);
    endtask

    typedef struct {
        int          s;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        il;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [31:0] er;
        logic        ei;
        int          el;
        logic        seen;

        tbl[0]  = '{0, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
        tbl[1]  = '{0, 4'h1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
        tbl[2]  = '{0, 4'h8, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1};
        tbl[3]  = '{0, 4'h9, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
        tbl[4]  = '{0, 4'h7, 32'h8000_00F0, 32'h0000_0004, 32'hF800_000F, 1'b0, 1'b0, 5};
        tbl[5]  = '{0, 4'h5, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1};
        tbl[6]  = '{1, 4'h6, 32'hF000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 9};
        tbl[7]  = '{0, 4'hC, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b1, 1};
        tbl[8]  = '{0, 4'hA, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1};
        tbl[9]  = '{0, 4'h2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1};
        tbl[10] = '{0, 4'h3, 32'h0F00_00F0, 32'h0000_0F00, 32'h0F00_0FF0, 1'b0, 1'b0, 1};
        tbl[11] = '{0, 4'h4, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000, 1'b1, 1'b0, 1};
        tbl[12] = '{1, 4'h7, 32'h8000_0000, 32'h0000_0005, 32'hFC00_0000, 1'b0, 1'b0, 3};

        // Reset held two cycles with requests pending: nothing is accepted
        rst_n = 1'b0;
        ctrl = 4'h0; a = 32'd1; b = 32'd2;
        iv[0] = 1'b1; iv[1] = 1'b1;
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            chk1($sformatf("rst%0d_in_ready", s), ir[s], 1'b1);
            chk1($sformatf("rst%0d_out_valid", s), ov[s], 1'b0);
            chk($sformatf("rst%0d_result", s), rs[s], 32'd0);
            chk1($sformatf("rst%0d_zero", s), zo[s], 1'b0);
            chk1($sformatf("rst%0d_illegal", s), il[s], 1'b0);
            chk1($sformatf("rst%0d_busy", s), bz[s], 1'b0);
        end
        iv[0] = 1'b0; iv[1] = 1'b0;
        rst_n = 1'b1;
        tick();
        chk1("rst_post_out_valid", ov[0], 1'b0);
        chk1("rst_post_busy", bz[0], 1'b0);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].s, tbl[i].c, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i),
                   tbl[i].r, tbl[i].z, tbl[i].il, tbl[i].lat);
        end

        // Backpressure: ADD 3+4 held in DONE while another request waits
        ctrl = 4'h0; a = 32'd3; b = 32'd4;
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        tick();
        ctrl = 4'h1; a = 32'd10; b = 32'd4;
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("bp%0d_out_valid", i), ov[0], 1'b1);
            chk($sformatf("bp%0d_result", i), rs[0], 32'd7);
            chk1($sformatf("bp%0d_in_ready", i), ir[0], 1'b0);
            tick();
        end
        ordy[0] = 1'b1;
        tick();
        chk1("bp_release_out_valid", ov[0], 1'b0);
        chk1("bp_release_in_ready", ir[0], 1'b1);
        chk("bp_release_result_kept", rs[0], 32'd7);
        tick();
        iv[0] = 1'b0;
        chk1("bp_next_out_valid", ov[0], 1'b1);
        chk("bp_next_result", rs[0], 32'd6);
        tick();
        chk1("bp_next_drop", ov[0], 1'b0);

        // Abort: reset during the 2nd SHIFT cycle of SLL by 20
        ctrl = 4'h5; a = 32'd1; b = 32'd20;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        chk1("abort_busy_shift", bz[0], 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("abort_busy_after_rst", bz[0], 1'b0);
        chk1("abort_in_ready_after_rst", ir[0], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ov[0]) seen = 1'b1;
            tick();
        end
        chk1("abort_no_out_valid", seen, 1'b0);
        run_op(0, 4'h0, 32'd3, 32'd4, "abort_add", 32'd7, 1'b0, 1'b0, 1);

        // Randomized operations against the reference model
        for (int i = 0; i < 80; i++) begin
            int          s;
            logic [3:0]  c;
            logic [31:0] ra, rb;
            s  = int'($urandom_range(0, 1));
            c  = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            model(c, ra, rb, (s == 1) ? 4 : 1, er, ei, el);
            run_op(s, c, ra, rb, $sformatf("rnd%0d", i), er, (er == 32'd0), ei, el);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
